// File: rtl/pipe_trace_pkg.sv
// Shared definitions for the pipeline trace unit: counter select codes, forwarding
// select codes and the trace record layout (timestamp field under PIPE_TRACE_TIMESTAMP_EN).
package pipe_trace_pkg;

    localparam logic [2:0] CNT_CYCLES  = 3'd0;
    localparam logic [2:0] CNT_RETIRED = 3'd1;
    localparam logic [2:0] CNT_STALLS  = 3'd2;
    localparam logic [2:0] CNT_FWD_A   = 3'd3;
    localparam logic [2:0] CNT_FWD_B   = 3'd4;
    localparam logic [2:0] CNT_HITS    = 3'd5;
    localparam logic [2:0] CNT_MISSES  = 3'd6;
    localparam logic [2:0] CNT_DROPS   = 3'd7;
    localparam int         NUM_CNT     = 8;

    // Same encoding the forwarding unit drives onto fwd_a/fwd_b.
    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam int REC_XLEN = 32;
    localparam int REC_TS_W = 32;

    // Record layout at default widths; the top builds the same layout at its own widths.
    typedef struct packed {
`ifdef PIPE_TRACE_TIMESTAMP_EN
        logic [REC_TS_W-1:0] stamp;
`endif
        logic [4:0]          rd;
        logic [REC_XLEN-1:0] data;
    } trace_rec_t;

    function automatic logic fwd_active(input logic [1:0] sel);
        return sel != FWD_NONE;
    endfunction

endpackage

// File: rtl/pipe_trace_fifo.sv
// Synchronous trace FIFO: wrap-bit pointers, valid/ready pop, drop-on-full and flush.
// Output is read straight from storage and forced to zero while empty.
module pipe_trace_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop_ready,
    output logic                       out_valid,
    output logic [W-1:0]               dout,
    output logic                       drop,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         full;
    logic         empty;
    logic         pop;
    logic         wr;

    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign out_valid = !empty;
    assign pop       = out_valid && pop_ready && !flush;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign wr        = push && !flush && (!full || pop);
    assign drop      = push && !flush && full && !pop;
    assign level     = wptr - rptr;
    assign dout      = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr)  wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pipe_trace_unit.sv
// Pipeline observability: wrapping event counters with a registered select mux and a
// write-back trace FIFO. PIPE_TRACE_TIMESTAMP_EN adds a cycle stamp per record and tr_time.
module pipe_trace_unit
    import pipe_trace_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 32,
    parameter int SKIP_X0 = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      clr,
    input  logic                      flush,
    input  logic                      stall,
    input  logic [1:0]                fwd_a,
    input  logic [1:0]                fwd_b,
    input  logic                      cache_access,
    input  logic                      cache_hit,
    input  logic                      wb_valid,
    input  logic [4:0]                wb_rd,
    input  logic [XLEN-1:0]           wb_data,
    output logic                      tr_valid,
    input  logic                      tr_ready,
    output logic [4:0]                tr_rd,
    output logic [XLEN-1:0]           tr_data,
`ifdef PIPE_TRACE_TIMESTAMP_EN
    output logic [CNT_W-1:0]          tr_time,
`endif
    input  logic [2:0]                cnt_sel,
    output logic [CNT_W-1:0]          cnt_value,
    output logic                      overflow,
    output logic [$clog2(DEPTH):0]    level
);
    typedef struct packed {
`ifdef PIPE_TRACE_TIMESTAMP_EN
        logic [CNT_W-1:0] stamp;
`endif
        logic [4:0]       rd;
        logic [XLEN-1:0]  data;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    logic [CNT_W-1:0]   cnt [NUM_CNT];
    logic [NUM_CNT-1:0] inc;
    logic               skip;
    logic               push;
    logic               drop;
    rec_t               rec_in;
    rec_t               rec_out;
    logic [REC_W-1:0]   fifo_dout;

    assign skip = (SKIP_X0 != 0) && (wb_rd == 5'd0);
    assign push = en && wb_valid && !skip;

    always_comb begin
        rec_in      = '0;
        rec_in.rd   = wb_rd;
        rec_in.data = wb_data;
`ifdef PIPE_TRACE_TIMESTAMP_EN
        // Stamp is the cycle count before this cycle's own increment.
        rec_in.stamp = cnt[CNT_CYCLES];
`endif
    end

    pipe_trace_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .din       (rec_in),
        .pop_ready (tr_ready),
        .out_valid (tr_valid),
        .dout      (fifo_dout),
        .drop      (drop),
        .level     (level)
    );

    assign rec_out = rec_t'(fifo_dout);
    assign tr_rd   = rec_out.rd;
    assign tr_data = rec_out.data;
`ifdef PIPE_TRACE_TIMESTAMP_EN
    assign tr_time = rec_out.stamp;
`endif

    always_comb begin
        inc              = '0;
        inc[CNT_CYCLES]  = en;
        inc[CNT_RETIRED] = push;
        inc[CNT_STALLS]  = en && stall;
        inc[CNT_FWD_A]   = en && fwd_active(fwd_a);
        inc[CNT_FWD_B]   = en && fwd_active(fwd_b);
        inc[CNT_HITS]    = en && cache_access && cache_hit;
        inc[CNT_MISSES]  = en && cache_access && !cache_hit;
        inc[CNT_DROPS]   = drop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
            overflow <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (inc[i]) cnt[i] <= cnt[i] + 1'b1;
            end
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_value <= '0;
        else       cnt_value <= cnt[cnt_sel];
    end

endmodule

// File: tb/tb_pipe_trace_unit.sv
// Self-checking bench for pipe_trace_unit (DEPTH=4, CNT_W=8) against a queue-based model.
`timescale 1ns/1ps
module tb_pipe_trace_unit;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int MODV  = 1 << CNT_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              en, clr, flush, stall, cache_access, cache_hit, wb_valid, tr_ready;
    logic [1:0]        fwd_a, fwd_b;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic [2:0]        cnt_sel;
    logic              tr_valid;
    logic [4:0]        tr_rd;
    logic [XLEN-1:0]   tr_data;
    logic [CNT_W-1:0]  cnt_value;
    logic              overflow;
    logic [LW-1:0]     level;
`ifdef PIPE_TRACE_TIMESTAMP_EN
    logic [CNT_W-1:0]  tr_time;
`endif

    always #5 clk = ~clk;

    pipe_trace_unit #(
        .XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W), .SKIP_X0(1)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .flush(flush), .stall(stall),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .cache_access(cache_access), .cache_hit(cache_hit),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_rd(tr_rd), .tr_data(tr_data),
`ifdef PIPE_TRACE_TIMESTAMP_EN
        .tr_time(tr_time),
`endif
        .cnt_sel(cnt_sel), .cnt_value(cnt_value), .overflow(overflow), .level(level)
    );

    // Reference model: event counts, a record queue and the sticky drop flag.
    int unsigned  m_cnt [8];
    logic [4:0]   q_rd [$];
    logic [31:0]  q_data [$];
    int unsigned  q_time [$];
    bit           m_ovf;
    int unsigned  m_cnt_value;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic int unsigned bump(input int unsigned x);
        return (x + 1) % MODV;
    endfunction

    task automatic idle_inputs();
        en = 0; clr = 0; flush = 0; stall = 0; fwd_a = 0; fwd_b = 0;
        cache_access = 0; cache_hit = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
        tr_ready = 0; cnt_sel = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        q_rd.delete(); q_data.delete(); q_time.delete();
        m_ovf = 0;
        m_cnt_value = 0;
    endtask

    task automatic tick();
        bit eligible, do_pop, do_drop;
        int unsigned ts;
        eligible = en && wb_valid && (wb_rd != 0);
        do_pop   = !flush && tr_ready && (q_rd.size() > 0);
        do_drop  = 0;
        ts       = m_cnt[0];
        m_cnt_value = m_cnt[cnt_sel];
        if (flush) begin
            q_rd.delete(); q_data.delete(); q_time.delete();
        end else begin
            if (do_pop) begin
                void'(q_rd.pop_front()); void'(q_data.pop_front()); void'(q_time.pop_front());
            end
            if (eligible) begin
                if (q_rd.size() == DEPTH) do_drop = 1;
                else begin
                    q_rd.push_back(wb_rd); q_data.push_back(wb_data); q_time.push_back(ts);
                end
            end
        end
        if (clr) begin
            for (int i = 0; i < 8; i++) m_cnt[i] = 0;
            m_ovf = 0;
        end else begin
            if (en)                                   m_cnt[0] = bump(m_cnt[0]);
            if (eligible)                             m_cnt[1] = bump(m_cnt[1]);
            if (en && stall)                          m_cnt[2] = bump(m_cnt[2]);
            if (en && fwd_a != 0)                     m_cnt[3] = bump(m_cnt[3]);
            if (en && fwd_b != 0)                     m_cnt[4] = bump(m_cnt[4]);
            if (en && cache_access && cache_hit)      m_cnt[5] = bump(m_cnt[5]);
            if (en && cache_access && !cache_hit)     m_cnt[6] = bump(m_cnt[6]);
            if (do_drop) begin
                m_cnt[7] = bump(m_cnt[7]);
                m_ovf = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        #1;
        n_tests++; if (tr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tr_valid got %0b want 0", tr_valid); end
        n_tests++; if (tr_rd !== 5'd0) begin n_fail++; $display("FAIL reset_tr_rd got %0d want 0", tr_rd); end
        n_tests++; if (tr_data !== '0) begin n_fail++; $display("FAIL reset_tr_data got %h want 0", tr_data); end
        n_tests++; if (level !== '0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
        n_tests++; if (cnt_value !== '0) begin n_fail++; $display("FAIL reset_cnt_value got %0d want 0", cnt_value); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
    endtask

    task automatic test_idle_cycles();
        do_reset();
        en = 1; cnt_sel = 0;
        repeat (10) tick();
        en = 0;
        tick();
        n_tests++; if (cnt_value !== 8'd10) begin n_fail++; $display("FAIL idle_cycles got %0d want 10", cnt_value); end
        for (int s = 1; s < 8; s++) begin
            cnt_sel = 3'(s);
            tick();
            n_tests++;
            if (cnt_value !== 8'd0) begin n_fail++; $display("FAIL idle_other_cnt sel=%0d got %0d want 0", s, cnt_value); end
        end
    endtask

    task automatic test_x0_filter();
        do_reset();
        en = 1;
        wb_valid = 1; wb_rd = 0; wb_data = 32'h5;
        tick();
        wb_valid = 0;
        n_tests++; if (tr_valid !== 1'b0) begin n_fail++; $display("FAIL x0_no_trace got tr_valid=%0b want 0", tr_valid); end
        cnt_sel = 1;
        tick();
        n_tests++; if (cnt_value !== 8'd0) begin n_fail++; $display("FAIL x0_retired got %0d want 0", cnt_value); end
        wb_valid = 1; wb_rd = 3; wb_data = 32'hDEADBEEF;
        tick();
        wb_valid = 0;
        n_tests++; if (tr_valid !== 1'b1) begin n_fail++; $display("FAIL x3_tr_valid got %0b want 1", tr_valid); end
        n_tests++; if (tr_rd !== 5'd3) begin n_fail++; $display("FAIL x3_tr_rd got %0d want 3", tr_rd); end
        n_tests++; if (tr_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL x3_tr_data got %h want deadbeef", tr_data); end
        tick();
        n_tests++; if (cnt_value !== 8'd1) begin n_fail++; $display("FAIL x3_retired got %0d want 1", cnt_value); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_data [7];
        do_reset();
        en = 1; tr_ready = 0;
        for (int i = 1; i <= 6; i++) begin
            wb_valid = 1; wb_rd = 5'(i); wb_data = $urandom;
            exp_data[i] = wb_data;
            tick();
        end
        wb_valid = 0;
        n_tests++; if (level !== LW'(4)) begin n_fail++; $display("FAIL ovf_level got %0d want 4", level); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b want 1", overflow); end
        cnt_sel = 7;
        tick();
        n_tests++; if (cnt_value !== 8'd2) begin n_fail++; $display("FAIL ovf_drop_cnt got %0d want 2", cnt_value); end
        n_tests++; if (tr_rd !== 5'd1) begin n_fail++; $display("FAIL ovf_hold_rd got %0d want 1", tr_rd); end
        tr_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            n_tests++;
            if (tr_valid !== 1'b1 || tr_rd !== 5'(i) || tr_data !== exp_data[i]) begin
                n_fail++;
                $display("FAIL ovf_drain[%0d] got v=%0b rd=%0d data=%h want v=1 rd=%0d data=%h",
                         i, tr_valid, tr_rd, tr_data, i, exp_data[i]);
            end
            tick();
        end
        tr_ready = 0;
        n_tests++; if (tr_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained got tr_valid=%0b want 0", tr_valid); end
    endtask

    task automatic test_back_to_back_full();
        do_reset();
        en = 1; tr_ready = 0;
        for (int i = 10; i <= 13; i++) begin
            wb_valid = 1; wb_rd = 5'(i); wb_data = 32'(i * 3);
            tick();
        end
        wb_valid = 1; wb_rd = 14; wb_data = 32'hCAFE0014; tr_ready = 1;
        tick();
        wb_valid = 0; tr_ready = 0;
        n_tests++; if (level !== LW'(4)) begin n_fail++; $display("FAIL b2b_level got %0d want 4", level); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow got %0b want 0", overflow); end
        cnt_sel = 7;
        tick();
        n_tests++; if (cnt_value !== 8'd0) begin n_fail++; $display("FAIL b2b_drops got %0d want 0", cnt_value); end
        tr_ready = 1;
        for (int i = 11; i <= 14; i++) begin
            n_tests++;
            if (tr_rd !== 5'(i)) begin n_fail++; $display("FAIL b2b_order got rd=%0d want %0d", tr_rd, i); end
            if (i == 14) begin
                n_tests++;
                if (tr_data !== 32'hCAFE0014) begin n_fail++; $display("FAIL b2b_newest got %h want cafe0014", tr_data); end
            end
            tick();
        end
        tr_ready = 0;
    endtask

    task automatic test_clr_flush();
        do_reset();
        en = 1; stall = 1;
        repeat (3) tick();
        clr = 1;
        tick();
        clr = 0; stall = 0; cnt_sel = 2;
        tick();
        n_tests++; if (cnt_value !== 8'd0) begin n_fail++; $display("FAIL clr_stall got %0d want 0", cnt_value); end
        wb_valid = 1; wb_rd = 5; wb_data = $urandom;
        tick();
        wb_valid = 0;
        n_tests++; if (tr_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid got %0b want 1", tr_valid); end
        flush = 1;
        tick();
        flush = 0;
        n_tests++; if (tr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %0b want 0", tr_valid); end
        n_tests++; if (level !== '0) begin n_fail++; $display("FAIL flush_level got %0d want 0", level); end
        cnt_sel = 1;
        tick();
        n_tests++; if (cnt_value !== 8'd1) begin n_fail++; $display("FAIL flush_keeps_cnt got %0d want 1", cnt_value); end
        cnt_sel = 0;
        tick();
        n_tests++; if (cnt_value !== CNT_W'(m_cnt_value)) begin n_fail++; $display("FAIL flush_cycles got %0d want %0d", cnt_value, m_cnt_value); end
    endtask

    task automatic test_wrap();
        do_reset();
        en = 1; cnt_sel = 0;
        repeat (255) tick();
        en = 0;
        tick();
        n_tests++; if (cnt_value !== 8'd255) begin n_fail++; $display("FAIL wrap_max got %0d want 255", cnt_value); end
        en = 1;
        tick();
        en = 0;
        tick();
        n_tests++; if (cnt_value !== 8'd0) begin n_fail++; $display("FAIL wrap_zero got %0d want 0", cnt_value); end
    endtask

`ifdef PIPE_TRACE_TIMESTAMP_EN
    task automatic test_timestamp();
        do_reset();
        en = 1;
        repeat (7) tick();
        wb_valid = 1; wb_rd = 7; wb_data = 32'h77;
        tick();
        wb_valid = 0;
        n_tests++; if (tr_time !== 8'd7) begin n_fail++; $display("FAIL ts_cycle7 got %0d want 7", tr_time); end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 400; it++) begin
            en           = ($urandom_range(0, 7) != 0);
            clr          = ($urandom_range(0, 39) == 0);
            flush        = ($urandom_range(0, 29) == 0);
            stall        = $urandom_range(0, 1);
            fwd_a        = 2'($urandom_range(0, 3));
            fwd_b        = 2'($urandom_range(0, 3));
            cache_access = $urandom_range(0, 1);
            cache_hit    = $urandom_range(0, 1);
            wb_valid     = ($urandom_range(0, 2) != 0);
            wb_rd        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            wb_data      = $urandom;
            tr_ready     = (it < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            cnt_sel      = 3'($urandom_range(0, 7));
            tick();
            n_tests++;
            if (tr_valid !== (q_rd.size() > 0)) begin n_fail++; $display("FAIL rnd_valid it=%0d got %0b want %0b", it, tr_valid, q_rd.size() > 0); end
            n_tests++;
            if (level !== LW'(q_rd.size())) begin n_fail++; $display("FAIL rnd_level it=%0d got %0d want %0d", it, level, q_rd.size()); end
            n_tests++;
            if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow it=%0d got %0b want %0b", it, overflow, m_ovf); end
            n_tests++;
            if (cnt_value !== CNT_W'(m_cnt_value)) begin n_fail++; $display("FAIL rnd_cnt it=%0d got %0d want %0d", it, cnt_value, m_cnt_value); end
            if (q_rd.size() > 0) begin
                n_tests++;
                if (tr_rd !== q_rd[0] || tr_data !== q_data[0]) begin
                    n_fail++;
                    $display("FAIL rnd_record it=%0d got rd=%0d data=%h want rd=%0d data=%h", it, tr_rd, tr_data, q_rd[0], q_data[0]);
                end
`ifdef PIPE_TRACE_TIMESTAMP_EN
                n_tests++;
                if (tr_time !== CNT_W'(q_time[0])) begin n_fail++; $display("FAIL rnd_time it=%0d got %0d want %0d", it, tr_time, q_time[0]); end
`endif
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        en = 1;
        for (int i = 1; i <= 2; i++) begin
            wb_valid = 1; wb_rd = 5'(i + 20); wb_data = $urandom;
            tick();
        end
        wb_valid = 0;
        #2;
        reset = 1;
        #1;
        n_tests++; if (tr_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %0b want 0", tr_valid); end
        n_tests++; if (level !== '0) begin n_fail++; $display("FAIL midrst_level got %0d want 0", level); end
        n_tests++; if (tr_data !== '0) begin n_fail++; $display("FAIL midrst_data got %h want 0", tr_data); end
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
        idle_inputs();
        tick();
        n_tests++; if (cnt_value !== 8'd0) begin n_fail++; $display("FAIL midrst_cnt got %0d want 0", cnt_value); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_cycles();
        test_x0_filter();
        test_overflow();
        test_back_to_back_full();
        test_clr_flush();
        test_wrap();
`ifdef PIPE_TRACE_TIMESTAMP_EN
        test_timestamp();
`endif
        test_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_trace_unit.md
# pipe_trace_unit

Synthesizable pipeline observability block for the pipelined processor: samples per-cycle pipeline events (stall, forwarding, cache hit/miss, write-back), maintains wrapping event counters, and buffers write-back records in a trace FIFO drained over a valid/ready port. It sits beside the core at top level. It replaces ad-hoc simulation-only monitoring with a hardware trace usable in simulation and on silicon. It is generalised over data width, FIFO depth, counter width and x0 filtering.

## Interface
Parameters:
- XLEN, 32, write-back data width
- DEPTH, 16, trace FIFO entries; power of two, ≥ 2
- CNT_W, 32, counter and timestamp width
- SKIP_X0, 1, when 1, write-backs to x0 are not traced

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- en  in  1  sampling enable; when 0 no counter increments and no FIFO pushes
- clr  in  1  synchronous clear of all counters and the overflow flag
- flush  in  1  synchronous FIFO empty
- stall  in  1  hazard stall this cycle
- fwd_a, fwd_b  in  2 each  forwarding select; nonzero means forwarded
- cache_access  in  1  cache lookup this cycle
- cache_hit  in  1  lookup hit; qualified by cache_access
- wb_valid  in  1  write-back occurs
- wb_rd  in  5  destination register
- wb_data  in  XLEN  write-back value
- tr_valid  out  1  trace record available
- tr_ready  in  1  consumer accepts record
- tr_rd  out  5  record register
- tr_data  out  XLEN  record data
- tr_time  out  CNT_W  record cycle stamp; present only with the macro defined
- cnt_sel  in  3  counter select
- cnt_value  out  CNT_W  selected counter, registered
- overflow  out  1  sticky: a record was dropped
- level  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Counters, each CNT_W wide and wrapping modulo 2^CNT_W. cnt_sel encoding: 0 cycles (en=1), 1 retired (traced-eligible wb), 2 stalls, 3 fwd_a≠0, 4 fwd_b≠0, 5 cache hits, 6 cache misses (access & !hit), 7 dropped records.
- If clr and an increment coincide, clr wins and the counter reads 0 next cycle.
- Push condition: en & wb_valid & !(SKIP_X0 & wb_rd==0). A push stores {wb_rd, wb_data[, cycle counter value]}.
- Full and no pop: the new record is dropped, overflow is set, and counter 7 increments. Oldest records are preserved.
- Full with simultaneous push and pop: both take effect, level is unchanged, and there is no drop.
- Empty with a push: the record becomes visible on tr_valid the next cycle. There is no fall-through.
- Pop occurs when tr_valid & tr_ready. The tr_* outputs are stable while tr_valid=1 and tr_ready=0.
- flush empties the FIFO and has priority over a same-cycle push and pop. It does not touch counters or overflow.
- clr does not flush the FIFO.
- Read and write pointers are $clog2(DEPTH)+1 bits with a wrap bit. Full means the MSBs differ and the LSBs are equal.

## Timing
- Reset values: all counters 0, pointers 0, level 0, tr_valid 0, tr_rd 0, tr_data 0, tr_time 0, cnt_value 0, overflow 0.
- Counter increment is visible in cnt_value 2 cycles after the event: 1 cycle for the counter update, 1 for the output register.
- cnt_sel change is reflected in cnt_value 1 cycle later.
- Push to tr_valid: 1 cycle. level updates 1 cycle after the push or pop.
- Reset asserted mid-stream clears everything immediately. In-flight records are lost and no partial record is emitted.
- The timestamp equals the cycles counter value in the push cycle, before that cycle's increment.

## Configuration
- PIPE_TRACE_TIMESTAMP_EN defined: each FIFO entry carries a CNT_W timestamp, and the tr_time port exists.
- PIPE_TRACE_TIMESTAMP_EN undefined: no tr_time port, and entries are 5+XLEN bits wide. Counter behaviour is identical in both cases.

## Structure
- Shared package pipe_trace_pkg holds: the cnt_sel encoding as localparams (CNT_CYCLES … CNT_DROPS), the packed trace-record struct typedef (with the macro-dependent timestamp field), and the fwd select encoding shared with the forwarding unit.
- One sub-module, pipe_trace_fifo: a parametrised synchronous FIFO with valid/ready pop, a full-drop signal, flush and level.
- Counters and the selection mux stay in the top.

## Test plan
- Reset, en=1, 10 idle cycles, cnt_sel=0 → cnt_value=10 two cycles after the last; all other counters 0.
- wb_valid to x0 with data 0x5, SKIP_X0=1 → no tr_valid, retired count 0. wb_valid to x3 with data 0xDEADBEEF → tr_valid next cycle with tr_rd=3, tr_data=0xDEADBEEF.
- DEPTH=4, tr_ready=0, 6 pushes → level=4, overflow=1, drop counter=2. Drain → records 1–4 come out in order.
- With FIFO full, push and pop in the same cycle → level stays 4, no drop, and the newest record appears last.
- clr coincident with a stall → stall counter reads 0. flush with tr_valid=1 → tr_valid=0 next cycle, counters retained.
- Macro defined: push in cycle 7 after reset release → tr_time=7. Counter at 2^CNT_W−1 (CNT_W=8) plus one event → wraps to 0.
